// File: rtl/button_debouncer.sv
// Per-button debouncer with press / release / long-press event pulses.
// Raw inputs pass through a two-flop synchroniser every clk; the per-button
// FSMs and their counters advance only on slow_clk_en ticks.
//
// state        | meaning
// RELEASED     | accepted level is 0, input agrees
// PRESS_PEND   | input went high, counting agreeing samples
// PRESSED      | accepted level is 1, hold counter running
// RELEASE_PEND | input went low while pressed, counting agreeing samples
module button_debouncer #(
  parameter int NUM_BTN        = 4,
  parameter int STABLE_SAMPLES = 4,
  parameter int LONG_TICKS     = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               slow_clk_en,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int SW = $clog2(STABLE_SAMPLES + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);

  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SAMPLES);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_TICKS);

  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_PEND   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_PEND = 2'd3;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;

  logic [1:0]    state_q  [NUM_BTN];
  logic [1:0]    state_d  [NUM_BTN];
  logic [SW-1:0] stable_q [NUM_BTN];
  logic [SW-1:0] stable_d [NUM_BTN];
  logic [HW-1:0] hold_q   [NUM_BTN];
  logic [HW-1:0] hold_d   [NUM_BTN];

  logic [NUM_BTN-1:0] long_done_q, long_done_d;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;
  logic [NUM_BTN-1:0] long_q, long_d;

  // Two-flop synchroniser, clocked every cycle independent of the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-button next-state, counters and event pulses; state moves only on ticks.
  always_comb begin
    long_done_d = long_done_q;
    level_d     = '0;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    for (int b = 0; b < NUM_BTN; b++) begin
      state_d[b]  = state_q[b];
      stable_d[b] = stable_q[b];
      hold_d[b]   = hold_q[b];
      if (slow_clk_en) begin
        case (state_q[b])
          RELEASED: begin
            if (sync2_q[b]) begin
              state_d[b]  = PRESS_PEND;
              stable_d[b] = SW'(1);
            end
          end
          PRESS_PEND: begin
            if (sync2_q[b]) begin
              if (stable_q[b] + SW'(1) == STABLE_MAX) begin
                state_d[b]     = PRESSED;
                stable_d[b]    = '0;
                hold_d[b]      = '0;
                long_done_d[b] = 1'b0;
                press_d[b]     = 1'b1;
              end else begin
                stable_d[b] = stable_q[b] + SW'(1);
              end
            end else begin
              state_d[b]  = RELEASED;
              stable_d[b] = '0;
            end
          end
          PRESSED: begin
            if (!sync2_q[b]) begin
              // The hold count does not advance on the tick that starts a release.
              state_d[b]  = RELEASE_PEND;
              stable_d[b] = SW'(1);
            end else if (hold_q[b] != HOLD_MAX) begin
              hold_d[b] = hold_q[b] + HW'(1);
              if ((hold_q[b] + HW'(1) == HOLD_MAX) && !long_done_q[b]) begin
                long_done_d[b] = 1'b1;
                long_d[b]      = 1'b1;
              end
            end
          end
          RELEASE_PEND: begin
            if (!sync2_q[b]) begin
              if (stable_q[b] + SW'(1) == STABLE_MAX) begin
                state_d[b]   = RELEASED;
                stable_d[b]  = '0;
                release_d[b] = 1'b1;
              end else begin
                stable_d[b] = stable_q[b] + SW'(1);
              end
            end else begin
              // Glitch on release: resume the press, keeping hold and long_done.
              state_d[b]  = PRESSED;
              stable_d[b] = '0;
            end
          end
          default: begin
            state_d[b]  = RELEASED;
            stable_d[b] = '0;
          end
        endcase
      end
      level_d[b] = (state_d[b] == PRESSED) || (state_d[b] == RELEASE_PEND);
    end
  end

  // FSM state and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BTN; b++) begin
        state_q[b]  <= RELEASED;
        stable_q[b] <= '0;
        hold_q[b]   <= '0;
      end
      long_done_q <= '0;
    end else begin
      for (int b = 0; b < NUM_BTN; b++) begin
        state_q[b]  <= state_d[b];
        stable_q[b] <= stable_d[b];
        hold_q[b]   <= hold_d[b];
      end
      long_done_q <= long_done_d;
    end
  end

  // Registered outputs: level follows the new state, pulses last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule
